// File: rtl/count_display_mux_pkg.sv
// count_display_mux_pkg: shared seven-segment patterns and digit-slot encoding
package count_display_mux_pkg;
    typedef enum logic [1:0] {
        DIG_Q_U = 2'd0,
        DIG_Q_T = 2'd1,
        DIG_W_U = 2'd2,
        DIG_W_T = 2'd3
    } dsel_t;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    // active-low {g,f,e,d,c,b,a}, index 9 first
    localparam logic [9:0][6:0] SEG_LUT = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
endpackage

// File: rtl/count_display_mux_seg7_decode.sv
// seg7_decode: BCD digit plus blank flag to active-low segment pattern
module seg7_decode
    import count_display_mux_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);
    assign seg = (blank || bcd > 4'd9) ? SEG_BLANK : SEG_LUT[bcd];
endmodule

// File: rtl/count_display_mux.sv
// count_display_mux: four-digit scanned display of a 4-bit count and its saturating wrap total
module count_display_mux
    import count_display_mux_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int WRAP_SAT = 99
) (
    input  logic       clk,
    input  logic       rs,
    input  logic [3:0] q_in,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [3:0] SAT_T = 4'(WRAP_SAT / 10);
    localparam logic [3:0] SAT_U = 4'(WRAP_SAT % 10);

    logic [3:0]    q_r, wrap_t, wrap_u, q_unit, digit;
    logic [SW-1:0] scan_cnt;
    dsel_t         dsel, dsel_n;
    logic          q_ten, adv, wrap, at_sat, blank;
    logic [6:0]    seg_n;

    // outputs are built from the next digit index so an/seg/dp switch together
    always_comb begin
        q_ten  = q_r >= 4'd10;
        q_unit = q_ten ? q_r - 4'd10 : q_r;
        adv    = scan_cnt == SW'(SCAN_DIV - 1);
        dsel_n = adv ? dsel_t'(dsel + 2'd1) : dsel;
        digit  = dsel_n == DIG_Q_U ? q_unit :
                 dsel_n == DIG_Q_T ? {3'b000, q_ten} :
                 dsel_n == DIG_W_U ? wrap_u : wrap_t;
        blank  = (dsel_n == DIG_Q_T && !q_ten) || (dsel_n == DIG_W_T && wrap_t == 4'd0);
        wrap   = q_r == 4'd15 && q_in == 4'd0;
        at_sat = wrap_t == SAT_T && wrap_u == SAT_U;
    end

    seg7_decode u_dec (
        .bcd   (digit),
        .blank (blank),
        .seg   (seg_n)
    );

    always_ff @(posedge clk) begin
        if (!rs) begin
            q_r      <= '0;
            wrap_t   <= '0;
            wrap_u   <= '0;
            scan_cnt <= '0;
            dsel     <= DIG_Q_U;
            seg      <= SEG_BLANK;
            an       <= 4'b1111;
            dp       <= 1'b1;
        end else begin
            q_r      <= q_in;
            scan_cnt <= adv ? '0 : scan_cnt + 1'b1;
            dsel     <= dsel_n;
            if (wrap && !at_sat) begin
                wrap_u <= wrap_u == 4'd9 ? 4'd0 : wrap_u + 4'd1;
                wrap_t <= wrap_u == 4'd9 ? wrap_t + 4'd1 : wrap_t;
            end
            seg <= seg_n;
            an  <= ~(4'b0001 << dsel_n);
            dp  <= dsel_n != DIG_W_U;
        end
    end
endmodule
